mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Single-port memory arbiter between the pipeline's instruction-fetch requester and data requester.
- Serializes both requesters onto one shared RAM port through a registered grant FSM.
- Data has priority, with a bounded starvation guard for instruction fetch.
- Tracks each RAM access with a watchdog counter and raises a sticky error on timeout.

Parameters:
STARVE_MAX, 4, consecutive data grants allowed while an instruction request is pending before instruction wins; range 1..15.
TIMEOUT, 64, cycles an access may wait for ram_ready before the error flag sets.

Ports:
CLK  input  1  clock, rising edge
RST  input  1  synchronous reset, active-high
iREN  input  1  instruction read request
iaddr  input  32  instruction address
iload  output  32  instruction read data
iwait  output  1  high while the instruction request is not yet complete
dREN  input  1  data read request
dWEN  input  1  data write request
daddr  input  32  data address
dstore  input  32  data write value
dload  output  32  data read data
dwait  output  1  high while the data request is not yet complete
ramREN  output  1  RAM read strobe
ramWEN  output  1  RAM write strobe
ramaddr  output  32  RAM address
ramstore  output  32  RAM write data
ramload  input  32  RAM read data
ram_ready  input  1  RAM access complete this cycle
err_timeout  output  1  sticky watchdog error

Behaviour:

Clock, reset and register values:
- Single clock CLK; reset RST is synchronous, active-high, sampled on the rising edge.
- Reset values: state=IDLE, grant counter=0, watchdog=0, err_timeout=0, latched address/data=0.
- Output values in reset and in IDLE: ramREN=0, ramWEN=0, ramaddr=0, ramstore=0.
- In IDLE, iwait=iREN and dwait=(dREN|dWEN).
- Reset asserted mid-access: FSM returns to IDLE at that edge and the access is abandoned; no further completion is reported.

FSM states: IDLE, IFETCH, DLOAD, DSTORE.

IDLE arbitration (evaluated every cycle):
- dWEN wins over dREN; dWEN&dREN together is treated as a write.
- Data request only -> DLOAD or DSTORE.
- Instruction request only -> IFETCH.
- Both requesting:
  - data wins unless grant counter == STARVE_MAX;
  - if grant counter == STARVE_MAX, IFETCH wins.
- On a grant, the winner's address (and dstore for writes) is latched into the address/data registers.

Serving states:
- Drive ramaddr/ramstore from the latched registers.
- ramREN=1 in IFETCH and DLOAD; ramWEN=1 in DSTORE.
- The loser's wait stays high.
- Completion is the cycle in which ram_ready=1:
  - the served wait drops to 0;
  - iload or dload = ramload, combinationally, in that cycle only (0 otherwise);
  - next state = IDLE.
- Minimum latency from request to wait low is 2 cycles: grant edge, then ready cycle.
- Back-to-back accesses have one IDLE bubble between them.

Grant counter (4 bits):
- Incremented, saturating at STARVE_MAX, on a data grant made while iREN=1.
- Cleared on any IFETCH grant, and on a data grant made while iREN=0.

Requester rules:
- Requesters hold the request and address until wait goes low.
- Dropping a request mid-access does not abort it: the RAM access completes, read data is discarded, and a write still commits.

Watchdog:
- Counts cycles spent in a serving state with ram_ready=0; clears in IDLE.
- On reaching TIMEOUT: err_timeout is set (sticky until RST) and the FSM forces return to IDLE; the served wait stays high so the requester re-arbitrates.

Boundary conditions:
- ram_ready in IDLE: ignored.
- A grant is only re-evaluated in IDLE; a new higher-priority request never preempts an access in progress.

Test Plan:
- Reset with iREN=1, daddr=0x40: every output equals its reset value; after RST falls, IFETCH is granted; ram_ready on the 2nd cycle -> iload=ramload=0x8C220004, iwait low that cycle.
- iREN=1 held with dREN=1 repeated, ram_ready=1 each access cycle, STARVE_MAX=4 -> 4 DLOAD grants, then 1 IFETCH grant, then counter=0 and data resumes.
- dREN=1 and dWEN=1 with daddr=0x100, dstore=0xDEADBEEF -> ramWEN=1, ramREN=0, ramaddr=0x100, ramstore=0xDEADBEEF.
- ram_ready delayed 5 cycles during DLOAD -> dwait high for 6 cycles total, dload valid only in the ready cycle, iwait high throughout.
- ram_ready never asserted with TIMEOUT=64 -> after 64 serving cycles err_timeout=1 and state=IDLE; err_timeout stays 1 until RST.
- RST asserted during DSTORE -> ramWEN=0 on the next edge, state IDLE, counter 0, no completion pulse.

Source files
------------

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter: data requester has priority over instruction fetch,
// with a bounded starvation guard and a sticky watchdog on stalled RAM accesses.
module mem_arbiter #(
    parameter int STARVE_MAX = 4,
    parameter int TIMEOUT    = 64
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic [31:0] iload,
    output logic        iwait,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic [31:0] dload,
    output logic        dwait,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic        ram_ready,
    output logic        err_timeout
);

    typedef enum logic [1:0] {IDLE, IFETCH, DLOAD, DSTORE} state_t;

    localparam int             WDW        = $clog2(TIMEOUT + 1);
    localparam logic [3:0]     STARVE_LIM = 4'(STARVE_MAX);
    localparam logic [WDW-1:0] WD_LAST    = WDW'(TIMEOUT - 1);

    state_t         state;
    state_t         next_state;
    logic [3:0]     grant_cnt;
    logic [WDW-1:0] wdog;
    logic [31:0]    lat_addr;
    logic [31:0]    lat_data;
    logic           data_req;
    logic           serving;
    logic           timeout;
    logic           done;

    assign data_req = dREN | dWEN;
    assign serving  = (state != IDLE);
    assign timeout  = serving && !ram_ready && (wdog == WD_LAST);
    // A reset arriving in the ready cycle suppresses the completion pulse.
    assign done     = serving && ram_ready && !RST;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (iREN && (!data_req || grant_cnt == STARVE_LIM)) begin
                    next_state = IFETCH;
                end else if (dWEN) begin
                    next_state = DSTORE;
                end else if (dREN) begin
                    next_state = DLOAD;
                end
            end
            default: begin
                if (ram_ready || timeout) begin
                    next_state = IDLE;
                end
            end
        endcase
    end

    // Grant bookkeeping happens only on IDLE grants; the watchdog only runs while serving.
    always_ff @(posedge CLK) begin
        if (RST) begin
            grant_cnt   <= '0;
            wdog        <= '0;
            lat_addr    <= '0;
            lat_data    <= '0;
            err_timeout <= 1'b0;
        end else begin
            if (state == IDLE) begin
                wdog <= '0;
                if (next_state == IFETCH) begin
                    lat_addr  <= iaddr;
                    grant_cnt <= '0;
                end else if (next_state != IDLE) begin
                    lat_addr <= daddr;
                    if (next_state == DSTORE) begin
                        lat_data <= dstore;
                    end
                    if (!iREN) begin
                        grant_cnt <= '0;
                    end else if (grant_cnt != STARVE_LIM) begin
                        grant_cnt <= grant_cnt + 4'd1;
                    end
                end
            end else if (ram_ready || timeout) begin
                wdog <= '0;
            end else begin
                wdog <= wdog + 1'b1;
            end
            if (timeout) begin
                err_timeout <= 1'b1;
            end
        end
    end

    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        iload    = '0;
        dload    = '0;
        iwait    = iREN;
        dwait    = data_req;
        case (state)
            IFETCH: begin
                ramREN   = 1'b1;
                ramaddr  = lat_addr;
                ramstore = lat_data;
                if (done) begin
                    iwait = 1'b0;
                    iload = iREN ? ramload : '0;
                end
            end
            DLOAD: begin
                ramREN   = 1'b1;
                ramaddr  = lat_addr;
                ramstore = lat_data;
                if (done) begin
                    dwait = 1'b0;
                    dload = data_req ? ramload : '0;
                end
            end
            DSTORE: begin
                ramWEN   = 1'b1;
                ramaddr  = lat_addr;
                ramstore = lat_data;
                if (done) begin
                    dwait = 1'b0;
                end
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus queues the expected RAM completion,
// a negedge monitor pops and compares whenever the RAM reports ready on a strobe.
module tb_mem_arbiter;

    localparam int STARVE_MAX = 4;
    localparam int TIMEOUT    = 64;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        iREN = 1'b0;
    logic [31:0] iaddr = '0;
    logic [31:0] iload;
    logic        iwait;
    logic        dREN = 1'b0;
    logic        dWEN = 1'b0;
    logic [31:0] daddr = '0;
    logic [31:0] dstore = '0;
    logic [31:0] dload;
    logic        dwait;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic        ram_ready = 1'b0;
    logic        err_timeout;

    typedef struct packed {
        logic        ren;
        logic        wen;
        logic [31:0] addr;
        logic [31:0] store;
        logic        iw;
        logic        dw;
        logic [31:0] il;
        logic [31:0] dl;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_done  = 0;
    int   n_pass  = 0;
    int   n_checks = 0;
    int   ready_delay = 0;
    int   serve_cyc = 0;

    mem_arbiter #(.STARVE_MAX(STARVE_MAX), .TIMEOUT(TIMEOUT)) dut (
        .CLK(CLK), .RST(RST),
        .iREN(iREN), .iaddr(iaddr), .iload(iload), .iwait(iwait),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dload(dload), .dwait(dwait),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ram_ready(ram_ready), .err_timeout(err_timeout)
    );

    always #5 CLK = ~CLK;

    // RAM model: read data is a fixed scramble of the address; ready after ready_delay stall cycles.
    assign ramload = ramaddr ^ 32'h8C22_0004;

    always @(posedge CLK) begin
        #1;
        if ((ramREN || ramWEN) && !RST) begin
            ram_ready = (serve_cyc == ready_delay);
            serve_cyc++;
        end else begin
            ram_ready = 1'b0;
            serve_cyc = 0;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    task automatic pushExp(input logic ren, input logic wen, input logic [31:0] addr,
                           input logic [31:0] store, input logic iw, input logic dw,
                           input logic [31:0] il, input logic [31:0] dl);
        exp_t e;
        e.ren = ren; e.wen = wen; e.addr = addr; e.store = store;
        e.iw = iw; e.dw = dw; e.il = il; e.dl = dl;
        exp_q.push_back(e);
    endtask

    task automatic applyStimulus(input logic ir, input logic [31:0] ia, input logic dr,
                                 input logic dw, input logic [31:0] da, input logic [31:0] ds);
        iREN = ir; iaddr = ia; dREN = dr; dWEN = dw; daddr = da; dstore = ds;
    endtask

    task automatic waitDone(input int target, input string name);
        int g = 0;
        while (n_done < target && g < 300) begin
            @(posedge CLK);
            g++;
        end
        checkOutput({name, ".done_in_time"}, 32'(n_done >= target), 32'd1);
        #1;
    endtask

    always @(negedge CLK) begin
        if ((ramREN || ramWEN) && ram_ready && !RST) begin
            n_done++;
            if (exp_q.size() == 0) begin
                checkOutput("sb.expected_pending", 32'(exp_q.size()), 32'd1);
            end else begin
                mon_e = exp_q.pop_front();
                checkOutput("sb.ramREN", 32'(ramREN), 32'(mon_e.ren));
                checkOutput("sb.ramWEN", 32'(ramWEN), 32'(mon_e.wen));
                checkOutput("sb.ramaddr", ramaddr, mon_e.addr);
                if (mon_e.wen) checkOutput("sb.ramstore", ramstore, mon_e.store);
                checkOutput("sb.iwait", 32'(iwait), 32'(mon_e.iw));
                checkOutput("sb.dwait", 32'(dwait), 32'(mon_e.dw));
                checkOutput("sb.iload", iload, mon_e.il);
                checkOutput("sb.dload", dload, mon_e.dl);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL global time limit expired");
        $fatal(1, "[TB] time limit");
    end

    initial begin
        int high;
        int cnt;
        int g;

        applyStimulus(1'b1, 32'h0, 1'b0, 1'b0, 32'h40, 32'h0);
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        checkOutput("rst.ramREN", 32'(ramREN), 32'd0);
        checkOutput("rst.ramWEN", 32'(ramWEN), 32'd0);
        checkOutput("rst.ramaddr", ramaddr, 32'h0);
        checkOutput("rst.ramstore", ramstore, 32'h0);
        checkOutput("rst.err", 32'(err_timeout), 32'd0);
        checkOutput("rst.iload", iload, 32'h0);
        checkOutput("rst.dload", dload, 32'h0);
        checkOutput("rst.iwait", 32'(iwait), 32'd1);
        checkOutput("rst.dwait", 32'(dwait), 32'd0);
        pushExp(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h8C22_0004, 32'h0);
        @(posedge CLK); #1;
        RST = 1'b0;
        waitDone(1, "ifetch0");
        iREN = 1'b0;

        // Four data grants starve fetch, then fetch wins once, then data resumes.
        repeat (4) pushExp(1'b1, 1'b0, 32'h2000, 32'h0, 1'b1, 1'b0, 32'h0, 32'h8C22_2004);
        pushExp(1'b1, 1'b0, 32'h1000, 32'h0, 1'b0, 1'b1, 32'h8C22_1004, 32'h0);
        pushExp(1'b1, 1'b0, 32'h2000, 32'h0, 1'b0, 1'b0, 32'h0, 32'h8C22_2004);
        applyStimulus(1'b1, 32'h1000, 1'b1, 1'b0, 32'h2000, 32'h0);
        waitDone(6, "starve");
        iREN = 1'b0;
        waitDone(7, "resume");
        dREN = 1'b0;

        pushExp(1'b0, 1'b1, 32'h100, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0, 32'h0);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h100, 32'hDEAD_BEEF);
        waitDone(8, "write");
        dREN = 1'b0; dWEN = 1'b0;

        @(negedge CLK);
        ready_delay = 5;
        @(posedge CLK); #1;
        pushExp(1'b1, 1'b0, 32'h300, 32'h0, 1'b1, 1'b0, 32'h0, 32'h8C22_0304);
        pushExp(1'b1, 1'b0, 32'h400, 32'h0, 1'b0, 1'b0, 32'h8C22_0404, 32'h0);
        applyStimulus(1'b1, 32'h400, 1'b1, 1'b0, 32'h300, 32'h0);
        high = 0;
        g = 0;
        do begin
            @(negedge CLK);
            g++;
            if (dwait) begin
                high++;
                checkOutput("dly.iwait_high", 32'(iwait), 32'd1);
                checkOutput("dly.dload_quiet", dload, 32'h0);
            end
        end while (dwait && g < 50);
        checkOutput("dly.dwait_cycles", 32'(high), 32'd6);
        @(posedge CLK); #1;
        dREN = 1'b0;
        @(negedge CLK);
        ready_delay = 0;
        waitDone(10, "fetch_after_delay");
        iREN = 1'b0;

        @(negedge CLK);
        ready_delay = 1000;
        @(posedge CLK); #1;
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h500, 32'h0);
        cnt = 0;
        g = 0;
        while (g < 200) begin
            @(negedge CLK);
            g++;
            if (ramREN) cnt++;
            else if (cnt > 0) break;
        end
        checkOutput("wd.serving_cycles", 32'(cnt), 32'd64);
        checkOutput("wd.err_set", 32'(err_timeout), 32'd1);
        checkOutput("wd.dwait_held", 32'(dwait), 32'd1);
        dREN = 1'b0;
        repeat (3) @(negedge CLK);
        checkOutput("wd.err_sticky", 32'(err_timeout), 32'd1);
        checkOutput("wd.idle_ramREN", 32'(ramREN), 32'd0);

        // Reset in the middle of a stalled store abandons it and clears the error.
        @(posedge CLK); #1;
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 32'h600, 32'h1234_5678);
        g = 0;
        do begin
            @(negedge CLK);
            g++;
        end while (!ramWEN && g < 20);
        checkOutput("rst2.store_started", 32'(ramWEN), 32'd1);
        checkOutput("rst2.store_addr", ramaddr, 32'h600);
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        checkOutput("rst2.ramWEN", 32'(ramWEN), 32'd0);
        checkOutput("rst2.ramaddr", ramaddr, 32'h0);
        checkOutput("rst2.ramstore", ramstore, 32'h0);
        checkOutput("rst2.err_cleared", 32'(err_timeout), 32'd0);
        checkOutput("rst2.dwait", 32'(dwait), 32'd1);
        dWEN = 1'b0;
        ready_delay = 0;
        @(posedge CLK); #1;
        RST = 1'b0;

        pushExp(1'b1, 1'b0, 32'h700, 32'h0, 1'b0, 1'b0, 32'h0, 32'h8C22_0704);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h700, 32'h0);
        waitDone(11, "post_reset_read");
        dREN = 1'b0;

        repeat (2) @(posedge CLK);
        checkOutput("sb.queue_drained", 32'(exp_q.size()), 32'd0);
        checkOutput("sb.completions", 32'(n_done), 32'd11);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
